sync_debounce_edge: RTL and testbench



---
 rtl/sync_debounce_edge_pkg.sv | 21 ++
 rtl/sync_debounce_chan.sv | 52 +++++
 rtl/sync_debounce_edge.sv | 67 ++++++
 tb/tb_sync_debounce_edge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_edge_pkg.sv
// Shared definitions for the synchroniser / debounce / edge-detect block.
package sync_pkg;

  // Fewest flops that still give a metastable first stage a full cycle
  // to resolve before anything downstream samples it.
  localparam int MIN_SYNC_STAGES = 2;

  // Ceiling log2, usable in constant expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_debounce_chan.sv
// One channel of debounce filtering plus rise/fall pulse generation.
// Takes an already-synchronised bit and only lets level_out follow it once
// the bit has disagreed with level_out for D consecutive clocks.
module sync_debounce_chan
  import sync_pkg::*;
#(
  parameter int   D         = 1,
  parameter int   CNT_W     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  // Terminal count: the D-th consecutive disagreeing cycle commits the level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

  // Counts consecutive cycles where sync_in differs from level_out.
  logic [CNT_W-1:0] cnt;

  // Qualification counter, filtered level and one-cycle edge pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      level_out  <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (sync_in == level_out) begin
        // Input agrees (or bounced back): any partial qualification is lost.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Disagreement held long enough: adopt it and flag the direction.
        level_out  <= sync_in;
        cnt        <= '0;
        rise_pulse <= sync_in;
        fall_pulse <= ~sync_in;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sync_debounce_edge.sv
// Multi-channel input conditioner: STAGES-deep synchroniser per bit,
// followed by a per-channel debounce filter and rise/fall pulse generator.
// DEBOUNCE_CYCLES = 0 bypasses filtering (identical to 1 cycle).
module sync_debounce_edge
  import sync_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Effective qualification length and the counter width that holds D-1.
  localparam int D     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CNT_W = clog2(D + 1);

  // A single-flop "synchroniser" gives no metastability protection.
  if (STAGES < MIN_SYNC_STAGES) begin : g_stages_check
    $error("sync_debounce_edge: STAGES must be at least 2");
  end

  // Synchroniser chain; stage 0 is the only flop that sees async_in.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  // Shift async_in through the chain with no logic between stages.
  // NOTE: this array is a handful of flops, not a RAM, so it is reset
  // along with everything else to give a defined sync_out out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_out = sync_q[STAGES-1];

  // One independent debounce / edge channel per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_debounce_chan #(
      .D         (D),
      .CNT_W     (CNT_W),
      .RESET_VAL (RESET_VAL[i])
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_in    (sync_q[STAGES-1][i]),
      .level_out  (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: reset values, sync latency,
// debounce qualification, glitch rejection, bounce, simultaneous channels,
// mid-count reset and the bypass configuration.
module tb_sync_debounce_edge;

  logic       clk;
  logic       rst_n;
  logic [3:0] async_a;
  logic [3:0] async_b;
  logic [0:0] async_c;

  logic [3:0] sync_a, level_a, rise_a, fall_a;
  logic [3:0] sync_b, level_b, rise_b, fall_b;
  logic [0:0] sync_c, level_c, rise_c, fall_c;

  int total;
  int bad;

  // Main configuration: 4 channels, 2 stages, 4-cycle debounce, reset 0.
  sync_debounce_edge #(
    .WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'h0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .async_in(async_a), .sync_out(sync_a),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a)
  );

  // Same configuration with a non-zero reset value.
  sync_debounce_edge #(
    .WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'hA)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .async_in(async_b), .sync_out(sync_b),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
  );

  // Deeper chain, debounce bypassed.
  sync_debounce_edge #(
    .WIDTH(1), .STAGES(3), .DEBOUNCE_CYCLES(0), .RESET_VAL(1'b0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .async_in(async_c), .sync_out(sync_c),
    .level_out(level_c), .rise_pulse(rise_c), .fall_pulse(fall_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int rises;
    int cnt_sync, cnt_level, cnt_rise, cnt_fall;

    total   = 0;
    bad     = 0;
    rst_n   = 1'b1;
    async_a = 4'hF;
    async_b = 4'hF;
    async_c = 1'b1;

    // ---- 1. Reset acts with no clock, and holds against toggling inputs.
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_sync_a", 32'(sync_a), 32'h0);
    check("rst_async_level_b", 32'(level_b), 32'hA);
    step(3);
    check("rst_sync_a", 32'(sync_a), 32'h0);
    check("rst_level_a", 32'(level_a), 32'h0);
    check("rst_pulses_a", 32'({rise_a, fall_a}), 32'h0);
    check("rst_sync_b", 32'(sync_b), 32'hA);
    check("rst_level_b", 32'(level_b), 32'hA);
    check("rst_pulses_b", 32'({rise_b, fall_b}), 32'h0);
    check("rst_level_c", 32'(level_c), 32'h0);

    async_a = 4'h0;
    async_c = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(2);
    check("idle_level_a", 32'(level_a), 32'h0);

    // ---- 2. Step on ch0: sync after edge 1, level+rise after edge 5.
    async_a = 4'b0001;
    step(1);
    check("e0_sync0", 32'(sync_a[0]), 32'd0);
    step(1);
    check("e1_sync0", 32'(sync_a[0]), 32'd1);
    step(3);
    check("e4_level0", 32'(level_a[0]), 32'd0);
    step(1);
    check("e5_level0", 32'(level_a[0]), 32'd1);
    check("e5_rise", 32'(rise_a), 32'b0001);
    check("e5_fall", 32'(fall_a), 32'b0000);
    step(1);
    check("e6_rise0", 32'(rise_a[0]), 32'd0);
    check("e6_level0", 32'(level_a[0]), 32'd1);

    // ---- 3. Glitch on ch1: three cycles high is swallowed.
    async_a = 4'b0011;
    step(3);
    async_a = 4'b0001;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (level_a[1] || rise_a[1]) rises++;
    end
    check("glitch3_no_change", 32'(rises), 32'd0);
    check("glitch3_level1", 32'(level_a[1]), 32'd0);

    // Four cycles high qualifies: exactly one rise, on edge 5.
    async_a = 4'b0011;
    rises = 0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (rise_a[1]) begin
        rises++;
        if (first < 0) first = i;
      end
    end
    check("hold4_rise_count", 32'(rises), 32'd1);
    check("hold4_rise_edge", 32'(first), 32'd5);
    check("hold4_level1", 32'(level_a[1]), 32'd1);

    // ---- 4. Bounce on ch2 with ch3 rising alongside.
    async_a = 4'b0111;
    step(8);
    check("pre_bounce_level", 32'(level_a), 32'b0111);
    check("pre_bounce_rise", 32'(rise_a), 32'b0000);
    async_a = 4'b0011;
    step(1);
    async_a = 4'b0111;
    step(1);
    async_a = 4'b1011;
    step(5);
    check("bounce_e6_level2", 32'(level_a[2]), 32'd1);
    check("bounce_e6_fall", 32'(fall_a), 32'b0000);
    step(1);
    check("bounce_e7_level", 32'(level_a), 32'b1011);
    check("bounce_e7_rise", 32'(rise_a), 32'b1000);
    check("bounce_e7_fall", 32'(fall_a), 32'b0100);
    step(1);
    check("bounce_e8_pulses", 32'({rise_a, fall_a}), 32'h0);

    // ---- 5. Reset asserted while ch0 counter sits at 2.
    async_a = 4'b1010;
    step(8);
    check("pre_rst_level", 32'(level_a), 32'b1010);
    async_a = 4'b1011;
    step(4);
    check("mid_count_level0", 32'(level_a[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sync_a", 32'(sync_a), 32'h0);
    check("midrst_level_a", 32'(level_a), 32'h0);
    check("midrst_pulses_a", 32'({rise_a, fall_a}), 32'h0);
    check("midrst_level_b", 32'(level_b), 32'hA);
    step(1);
    @(negedge clk) rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (first < 0 && rise_a[0]) first = i;
    end
    check("post_rst_rise_edge", 32'(first), 32'd6);
    check("post_rst_level_a", 32'(level_a), 32'b1011);
    check("post_rst_level_b", 32'(level_b), 32'hF);

    // ---- 6. STAGES=3, bypass debounce: rise on 4th edge after sampling.
    async_c = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (first < 0 && rise_c[0]) first = i;
    end
    check("bypass_rise_edge", 32'(first), 32'd4);
    check("bypass_level", 32'(level_c), 32'd1);
    async_c = 1'b0;
    step(8);
    check("bypass_level_low", 32'(level_c), 32'd0);

    // One-cycle glitch passes straight through in bypass.
    async_c = 1'b1;
    step(1);
    async_c = 1'b0;
    cnt_sync  = 0;
    cnt_level = 0;
    cnt_rise  = 0;
    cnt_fall  = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (sync_c[0])  cnt_sync++;
      if (level_c[0]) cnt_level++;
      if (rise_c[0])  cnt_rise++;
      if (fall_c[0])  cnt_fall++;
    end
    check("glitch_c_sync", 32'(cnt_sync), 32'd1);
    check("glitch_c_level", 32'(cnt_level), 32'd1);
    check("glitch_c_rise", 32'(cnt_rise), 32'd1);
    check("glitch_c_fall", 32'(cnt_fall), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
